// File: rtl/inst_inject_ctrl_pkg.sv
// Shared constants for the interactive-build instruction injector and its host-side peers.
package inst_inject_ctrl_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 6;
  localparam int unsigned NUM_REGS_DEFAULT     = 32;
  localparam int unsigned REG_AW_DEFAULT       = 5;

  // Sequencer states
  localparam int unsigned STATE_W  = 3;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_ISSUE = 3'd1;
  localparam logic [2:0]  ST_DRAIN = 3'd2;
  localparam logic [2:0]  ST_READ  = 3'd3;
  localparam logic [2:0]  ST_SEND  = 3'd4;

endpackage

// File: rtl/inst_inject_ctrl.sv
// Injects one host instruction into the core fetch stage, drains the pipeline
// with NOPs, then streams the whole register file back to the host.
module inst_inject_ctrl #(
  parameter int unsigned DRAIN_CYCLES = inst_inject_ctrl_pkg::DRAIN_CYCLES_DEFAULT,
  parameter int unsigned NUM_REGS     = inst_inject_ctrl_pkg::NUM_REGS_DEFAULT,
  parameter int unsigned REG_AW       = inst_inject_ctrl_pkg::REG_AW_DEFAULT,
  parameter logic [31:0] NOP_INSTR    = inst_inject_ctrl_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_in_data,
  input  logic              instr_in_valid,
  output logic              instr_in_ready,
  output logic [31:0]       cpu_inst,
  output logic [REG_AW-1:0] dbg_rd_addr,
  input  logic [31:0]       dbg_rd_data,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  import inst_inject_ctrl_pkg::*;

  // Drain counter only has to hold DRAIN_CYCLES-1
  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0]  idx_q, idx_d;
  logic [31:0]        cpu_inst_q, cpu_inst_d;
  logic [REG_AW-1:0]  addr_q, addr_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;

  // Host may hand over a word only while nothing is in flight
  assign instr_in_ready = (state_q == ST_IDLE);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cpu_inst_d  = cpu_inst_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        cpu_inst_d = NOP_INSTR;
        if (instr_in_valid) begin
          cpu_inst_d = instr_in_data;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cpu_inst_d = NOP_INSTR;
        cnt_d      = CNT_W'(DRAIN_CYCLES - 1);
        state_d    = ST_DRAIN;
      end
      ST_DRAIN: begin
        cpu_inst_d = NOP_INSTR;
        if (cnt_q == '0) begin
          idx_d   = '0;
          addr_d  = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READ: begin
        // Address was presented last cycle, so read data is valid now
        out_data_d  = dbg_rd_data;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == LAST_IDX);
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + REG_AW'(1);
            addr_d  = idx_q + REG_AW'(1);
            state_d = ST_READ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      cpu_inst_q  <= NOP_INSTR;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cpu_inst_q  <= cpu_inst_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_inst    = cpu_inst_q;
  assign dbg_rd_addr = addr_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_inst_inject_ctrl.sv
// Bench for inst_inject_ctrl: a stub core/regfile reacts to injected addi words,
// and a cycle-level reference model predicts the readback stream.
module tb_inst_inject_ctrl;

  import inst_inject_ctrl_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned D0 = 6;
  localparam int unsigned D1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT 0: default drain, DUT 1: single-cycle drain
  logic [31:0] in_data0 = '0, in_data1 = '0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        in_ready0, in_ready1;
  logic [31:0] cpu_inst0, cpu_inst1;
  logic [4:0]  addr0, addr1;
  logic [31:0] rd_data0, rd_data1;
  logic [31:0] out_data0, out_data1;
  logic        out_valid0, out_valid1;
  logic        out_ready0 = 1'b0, out_ready1 = 1'b0;
  logic        out_last0, out_last1;
  logic        busy0, busy1;

  inst_inject_ctrl dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_in_data(in_data0), .instr_in_valid(in_valid0), .instr_in_ready(in_ready0),
    .cpu_inst(cpu_inst0), .dbg_rd_addr(addr0), .dbg_rd_data(rd_data0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_last(out_last0), .busy(busy0)
  );

  inst_inject_ctrl #(.DRAIN_CYCLES(D1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .instr_in_data(in_data1), .instr_in_valid(in_valid1), .instr_in_ready(in_ready1),
    .cpu_inst(cpu_inst1), .dbg_rd_addr(addr1), .dbg_rd_data(rd_data1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1)
  );

  // Stub core: executes "addi rd, x0, imm" seen on either fetch bus; regfile read is combinational
  logic [31:0] core_regs [N];
  logic [31:0] seed_vals [N];
  logic        seed_now = 1'b1;

  function automatic bit is_li(input logic [31:0] w);
    return (w[6:0] == 7'h13) && (w[14:12] == 3'd0) && (w[19:15] == 5'd0) && (w[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] li_value(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  always @(negedge clk) begin
    if (seed_now) begin
      for (int i = 0; i < N; i++) core_regs[i] <= seed_vals[i];
    end else begin
      if (is_li(cpu_inst0)) core_regs[cpu_inst0[11:7]] <= li_value(cpu_inst0);
      if (is_li(cpu_inst1)) core_regs[cpu_inst1[11:7]] <= li_value(cpu_inst1);
    end
  end

  assign rd_data0 = core_regs[addr0];
  assign rd_data1 = core_regs[addr1];

  // Observation mux for the DUT under test
  bit          sel = 1'b0;
  logic [31:0] o_cpu, o_data;
  logic [4:0]  o_addr;
  logic        o_ready, o_valid, o_last, o_busy;
  always_comb begin
    o_cpu   = sel ? cpu_inst1  : cpu_inst0;
    o_data  = sel ? out_data1  : out_data0;
    o_addr  = sel ? addr1      : addr0;
    o_ready = sel ? in_ready1  : in_ready0;
    o_valid = sel ? out_valid1 : out_valid0;
    o_last  = sel ? out_last1  : out_last0;
    o_busy  = sel ? busy1      : busy0;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model_regs [N];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_in(input logic v, input logic [31:0] d);
    if (sel) begin in_valid1 = v; in_data1 = d; end
    else     begin in_valid0 = v; in_data0 = d; end
  endtask

  task automatic drive_ready(input logic r);
    if (sel) out_ready1 = r;
    else     out_ready0 = r;
  endtask

  function automatic logic [31:0] rand_li();
    logic [4:0]  rd;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 31));
    imm = 12'($urandom);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  // One full transaction, entered and left at a negedge while the DUT is idle.
  // mode: 0 host always ready, 1 random ready, 2 ten-cycle stall on word 3,
  //       3 always ready plus a rejected word offered from cycle 3 onward.
  task automatic run_txn(input bit s, input logic [31:0] word, input int d,
                         input int mode, input logic [31:0] rej_word);
    logic [31:0] exp_w [N];
    int  w, nv, done_c, st;
    bit  finished, r;
    sel = s;
    check_eq("ready_before_issue", 32'(o_ready), 32'd1);
    drive_in(1'b1, word);
    if (is_li(word)) model_regs[word[11:7]] = li_value(word);
    for (int i = 0; i < N; i++) exp_w[i] = model_regs[i];
    @(posedge clk);
    #1 drive_in(1'b0, '0);
    w = 0; nv = d + 3; done_c = -1; st = 0; finished = 1'b0;
    for (int c = 1; c < 3000 && !finished; c++) begin
      @(negedge clk);
      check_eq($sformatf("cpu_inst_c%0d", c), o_cpu, (c == 1) ? word : NOP_INSTR);
      if (done_c >= 0 && c == done_c + 1) begin
        check_eq("ready_after_stream", 32'(o_ready), 32'd1);
        check_eq("busy_after_stream", 32'(o_busy), 32'd0);
        check_eq("valid_after_stream", 32'(o_valid), 32'd0);
        finished = 1'b1;
      end else begin
        check_eq($sformatf("ready_busy_c%0d", c), 32'(o_ready), 32'd0);
        check_eq($sformatf("busy_c%0d", c), 32'(o_busy), 32'd1);
        if (mode == 3 && c == 3) drive_in(1'b1, rej_word);
        check_eq($sformatf("out_valid_c%0d", c), 32'(o_valid), 32'((c >= nv) && (w < N)));
        if ((c >= nv) && (w < N)) begin
          check_eq($sformatf("data_w%0d", w), o_data, exp_w[w]);
          check_eq($sformatf("last_w%0d", w), 32'(o_last), 32'(w == N - 1));
          check_eq($sformatf("addr_w%0d", w), 32'(o_addr), 32'(w));
          case (mode)
            1:       r = ($urandom_range(0, 3) != 0);
            2:       r = !(w == 3 && st < 10);
            default: r = 1'b1;
          endcase
          if (mode == 2 && !r) st++;
          drive_ready(r);
          if (r) begin
            w++;
            nv = c + 2;
            if (w == N) done_c = c;
          end
        end else begin
          drive_ready(1'($urandom_range(0, 1)));
        end
      end
    end
    if (!finished) check_eq("stream_timeout_words", 32'(w), 32'(N));
  endtask

  int vcount;

  initial begin
    for (int i = 0; i < N; i++) begin
      seed_vals[i]  = $urandom;
      model_regs[i] = seed_vals[i];
    end
    @(negedge clk);
    #1 seed_now = 1'b0;

    // Asynchronous reset asserted mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_cpu_inst", cpu_inst0, NOP_INSTR);
    check_eq("rst_out_valid", 32'(out_valid0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_out_last", 32'(out_last0), 32'd0);
    check_eq("rst_addr", 32'(addr0), 32'd0);
    check_eq("rst_out_data", out_data0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(in_ready0), 32'd1);

    // addi x1,x0,5 with host always ready
    run_txn(1'b0, 32'h0050_0093, D0, 0, '0);
    check_eq("model_x1_is_5", model_regs[1], 32'd5);

    // Backpressure on word 3
    run_txn(1'b0, rand_li(), D0, 2, '0);

    // NOP word issued normally while a second word is refused until the stream ends
    run_txn(1'b0, NOP_INSTR, D0, 3, 32'h00A0_0113);
    run_txn(1'b0, 32'h00A0_0113, D0, 1, '0);
    check_eq("model_x2_is_10", model_regs[2], 32'd10);

    // Random words, random host backpressure
    for (int k = 0; k < 5; k++) run_txn(1'b0, rand_li(), D0, 1, '0);

    // Reset during the drain window
    sel = 1'b0;
    drive_in(1'b1, 32'h04D0_0293);
    model_regs[5] = 32'd77;
    @(posedge clk);
    #1 drive_in(1'b0, '0);
    for (int c = 1; c < 4; c++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("drain_rst_cpu_inst", cpu_inst0, NOP_INSTR);
    check_eq("drain_rst_valid", 32'(out_valid0), 32'd0);
    check_eq("drain_rst_busy", 32'(busy0), 32'd0);
    check_eq("drain_rst_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready0 = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid0 || busy0) vcount++;
    end
    check_eq("no_words_after_reset", 32'(vcount), 32'd0);

    // Single-cycle drain build
    run_txn(1'b1, 32'h0030_0193, D1, 0, '0);
    run_txn(1'b1, rand_li(), D1, 1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_inject_ctrl.md
Name: inst_inject_ctrl

Overview:
- Host-side sequencer for the 5-stage RV32 core in the interactive (UART REPL) build.
- Accepts one 32-bit instruction word from the host link and drives it onto the core's instruction-fetch input for exactly one cycle. It then feeds NOPs until the pipeline has drained.
- After the drain it walks the register file through a debug read port and streams all register values back to the host over a valid/ready interface.
- Sits between the UART word assembler and the core. Its cpu_inst output replaces instruction memory.

Parameters:
- DRAIN_CYCLES, 6, number of NOP cycles after issue before register readback (covers IF..WB plus regfile write).
- NUM_REGS, 32, number of architectural registers streamed back.
- REG_AW, 5, register address width; must satisfy 2**REG_AW >= NUM_REGS.
- NOP_INSTR, 32'h00000013, word driven when no instruction is being issued (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_in_data  in  32  instruction word from the host link.
- instr_in_valid  in  1  instr_in_data is valid.
- instr_in_ready  out  1  block can accept a word; combinational, high only in IDLE.
- cpu_inst  out  32  registered instruction word to the core fetch stage.
- dbg_rd_addr  out  REG_AW  registered regfile debug read address.
- dbg_rd_data  in  32  regfile debug read data; valid one cycle after the address.
- out_data  out  32  register value to the host.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts out_data.
- out_last  out  1  marks the final register word (index NUM_REGS-1).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cpu_inst=NOP_INSTR, dbg_rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0.
  - instr_in_ready follows state, so it is 1 after reset is released.
- States: IDLE, ISSUE, DRAIN, READ, SEND. An internal register idx (REG_AW bits) tracks the stream position; an internal down-counter cnt tracks the drain.
- IDLE:
  - On valid&ready at an edge: cpu_inst<=instr_in_data, state<=ISSUE.
  - Otherwise cpu_inst holds NOP_INSTR.
- ISSUE (exactly 1 cycle):
  - At the edge: cpu_inst<=NOP_INSTR, cnt<=DRAIN_CYCLES-1, state<=DRAIN.
- DRAIN (exactly DRAIN_CYCLES cycles):
  - cpu_inst=NOP_INSTR throughout.
  - When cnt==0: idx<=0, dbg_rd_addr<=0, state<=READ.
  - Otherwise cnt<=cnt-1.
- READ (1 cycle, address in flight):
  - At the edge: out_data<=dbg_rd_data, out_valid<=1, out_last<=(idx==NUM_REGS-1), state<=SEND.
- SEND:
  - While out_valid & !out_ready: out_data, out_last, dbg_rd_addr and idx hold.
  - On out_valid&out_ready: out_valid<=0, out_last<=0.
    - If out_last: state<=IDLE.
    - Else: idx<=idx+1, dbg_rd_addr<=idx+1, state<=READ.
- Timing (accept edge = cycle 0, D=DRAIN_CYCLES):
  - cpu_inst carries the word in cycle 1 only.
  - First out_valid in cycle D+3.
  - With out_ready tied high: one word every 2 cycles. Last word in cycle D+3+2*(NUM_REGS-1). instr_in_ready is high again the following cycle.
- Boundaries:
  - instr_in_valid while busy: ignored (ready=0), with no side effects.
  - A word equal to NOP_INSTR is still issued and streamed normally.
  - x0 is streamed as returned by the regfile; no special casing here.
  - idx never wraps; out_last terminates the stream.
  - Reset mid-operation (any state): immediate return to the reset values. No partial stream resumes; the host must re-send.
  - The block has no stall input; the core's fence/branch flushes are irrelevant because cpu_inst is the only fetch source.

Decomposition:
- Shared package: NOP_INSTR constant, state enum (IDLE/ISSUE/DRAIN/READ/SEND), default DRAIN_CYCLES and NUM_REGS constants, reused by the UART word assembler and the testbench.
- Single module. The drain counter and the stream index are small enough to stay inline; no sub-module.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> cpu_inst=0x00000013, out_valid=0, busy=0 immediately. After release, instr_in_ready=1.
- Issue 0x00500093 (addi x1,x0,5), out_ready=1:
  - cpu_inst=0x00500093 in cycle 1 only, NOP afterwards.
  - First out_valid in cycle 9.
  - 32 words, word index 1 = 0x00000005.
  - out_last only on word 31, in cycle 71.
  - instr_in_ready=1 in cycle 72.
- Backpressure: out_ready=0 for 10 cycles while word 3 is presented -> out_valid stays 1, and out_data, dbg_rd_addr=3, out_last=0 remain stable. The stream resumes in order with no skipped or duplicated index.
- Busy rejection: assert instr_in_valid with word 0x00A00113 during DRAIN -> instr_in_ready=0, cpu_inst stays NOP. The word is accepted only after the first stream ends, and x2=10 appears in the second stream.
- Reset in DRAIN (cycle 4): rst_n=0 -> state IDLE, cpu_inst NOP, out_valid=0 asynchronously. No output words follow after release.
- DRAIN_CYCLES=1 build: first out_valid in cycle 4, and the 32-word stream is otherwise identical.
